musa_program_loader: RTL and testbench

- Boot/load controller for the MUSA core.
- Accepts a program as a valid/ready word stream and writes it into instruction memory from BASE_ADDR upward.
- Then releases the core from reset, enables it, and counts execution cycles until the core signals halt or a timeout expires.
- Replaces clock gating of the datapath with an explicit core_en/core_rst_n pair. Sits between the test/host interface and the dataPath.

---
 rtl/musa_loader_pkg.sv | 21 ++
 rtl/musa_run_counter.sv | 39 +++
 rtl/musa_program_loader.sv | 207 ++++++++++++++++++++
 tb/tb_musa_program_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/musa_loader_pkg.sv
// Shared types for the MUSA program loader: controller states and error codes.
package musa_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        DONE,
        ERR
    } loader_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    function automatic logic is_busy(input loader_state_e s);
        return (s == LOAD) || (s == ARM) || (s == RUN);
    endfunction

endpackage

// File: rtl/musa_run_counter.sv
// Saturating run-cycle counter with synchronous clear and a TIMEOUT-1 compare
// (TIMEOUT of 0 never times out).
module musa_run_counter #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign timeout_o = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/musa_program_loader.sv
// Boot/load controller: streams a program into imem, then releases and times the core.
// Optional LOADER_CHECKSUM_EN adds a running modulo-2^DATA_W sum of accepted beats.
module musa_program_loader
    import musa_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic              core_halt,
    output logic [CNT_W-1:0]  run_cycles,
    output logic [ADDR_W:0]   words_loaded,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              core_en_q, core_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              session_start;
    logic              cnt_clr;
    logic              cnt_en;
    logic              timeout;

    musa_run_counter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_run_counter (
        .clk      (clk),
        .rst_n    (rst),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .count_o  (run_cycles),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        words_d       = words_q;
        err_code_d    = err_code_q;
        session_start = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d       = LOAD;
                    session_start = 1'b1;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr_q;
                    imem_wdata_d = ld_data;
                    words_d      = words_q + (ADDR_W+1)'(1);
                    if (ptr_q != '1) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                    if (ld_last) begin
                        state_d = ARM;
                    end else if (ptr_q == '1) begin
                        state_d    = ERR;
                        err_code_d = ERR_OVERFLOW;
                    end
                end
            end
            ARM: state_d = RUN;
            RUN: begin
                cnt_en = 1'b1;
                if (core_halt) begin
                    state_d = DONE;
                end else if (timeout) begin
                    // The timing-out cycle is not counted, leaving run_cycles at TIMEOUT-1.
                    state_d    = ERR;
                    err_code_d = ERR_TIMEOUT;
                    cnt_en     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (session_start || abort) begin
            ptr_d      = BASE;
            words_d    = '0;
            err_code_d = ERR_NONE;
            cnt_clr    = 1'b1;
        end
        if (abort) begin
            state_d   = IDLE;
            imem_we_d = 1'b0;
            cnt_en    = 1'b0;
        end

        // Status outputs are registered from the next state so they track state_q exactly.
        core_en_d    = (state_d == RUN);
        core_rst_n_d = (state_d == RUN) || (state_d == DONE) || (state_d == ERR);
        busy_d       = is_busy(state_d);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= BASE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            words_q      <= '0;
            err_code_q   <= ERR_NONE;
            core_rst_n_q <= 1'b0;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            words_q      <= words_d;
            err_code_q   <= err_code_d;
            core_rst_n_q <= core_rst_n_d;
            core_en_q    <= core_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign ld_ready     = (state_q == LOAD);
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign words_loaded = words_q;
    assign err_code     = err_code_q;
    assign core_rst_n   = core_rst_n_q;
    assign core_en      = core_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (cnt_clr) begin
            csum_d = '0;
        end else if (imem_we_d) begin
            csum_d = csum_q + ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    // Build without the running program sum.
`endif

endmodule

// File: tb/tb_musa_program_loader.sv
// Bench for musa_program_loader: a default instance (A) and a small ADDR_W=2/TIMEOUT=8 instance (B) share stimulus.
module tb_musa_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, ld_valid, ld_last, core_halt;
    logic [31:0] ld_data;

    logic        ld_ready_a, imem_we_a, core_rst_n_a, core_en_a, busy_a, done_a, error_a;
    logic [9:0]  imem_addr_a;
    logic [31:0] imem_wdata_a, run_a;
    logic [10:0] words_a;
    logic [1:0]  err_a;

    logic        ld_ready_b, imem_we_b, core_rst_n_b, core_en_b, busy_b, done_b, error_b;
    logic [1:0]  imem_addr_b;
    logic [31:0] imem_wdata_b, run_b;
    logic [2:0]  words_b;
    logic [1:0]  err_b;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_a, checksum_b;
`endif

    musa_program_loader dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .core_rst_n(core_rst_n_a), .core_en(core_en_a), .core_halt(core_halt),
        .run_cycles(run_a), .words_loaded(words_a), .busy(busy_a), .done(done_a),
        .error(error_a), .err_code(err_a)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum_a)
`endif
    );

    musa_program_loader #(.ADDR_W(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .core_rst_n(core_rst_n_b), .core_en(core_en_b), .core_halt(core_halt),
        .run_cycles(run_b), .words_loaded(words_b), .busy(busy_b), .done(done_b),
        .error(error_b), .err_code(err_b)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum_b)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];

    always @(negedge clk) begin
        if (imem_we_a) qa.push_back('{cyc, int'(imem_addr_a), imem_wdata_a});
        if (imem_we_b) qb.push_back('{cyc, int'(imem_addr_b), imem_wdata_b});
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program beats and the idle cycles inserted before each beat.
    logic [31:0] sd[$];
    int          sg[$];

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input bit with_last);
        for (int i = 0; i < sd.size(); i++) begin
            ld_valid = 1'b0;
            repeat (sg[i]) tick();
            ld_valid = 1'b1;
            ld_data  = sd[i];
            ld_last  = with_last && (i == sd.size() - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Expected write i: address i, data sd[i], spaced sg[i]+1 cycles after write i-1.
    task automatic check_wr(input bit isb, input int n_exp);
        wr_t w;
        int  prev;
        int  got_n;
        got_n = isb ? qb.size() : qa.size();
        check(isb ? "wrB_count" : "wrA_count", got_n, n_exp);
        prev = 0;
        for (int i = 0; i < n_exp && i < got_n; i++) begin
            w = isb ? qb[i] : qa[i];
            check(isb ? "wrB_addr" : "wrA_addr", w.addr, i);
            check(isb ? "wrB_data" : "wrA_data", w.data, sd[i]);
            if (i > 0) check(isb ? "wrB_spacing" : "wrA_spacing", w.cyc - prev, sg[i] + 1);
            prev = w.cyc;
        end
        if (isb) qb.delete(); else qa.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_A_data"}, {imem_wdata_a, run_a}, '0);
        check({tag, "_A_ctrl"}, {ld_ready_a, imem_we_a, imem_addr_a, core_rst_n_a, core_en_a,
                                 words_a, busy_a, done_a, error_a, err_a}, '0);
        check({tag, "_B_data"}, {imem_wdata_b, run_b}, '0);
        check({tag, "_B_ctrl"}, {ld_ready_b, imem_we_b, imem_addr_b, core_rst_n_b, core_en_b,
                                 words_b, busy_b, done_b, error_b, err_b}, '0);
    endtask

    // Full session: start, stream sd with a last beat, run h cycles with halt on the h-th.
    task automatic session(input int h);
        int          n;
        int          acc_b;
        bit          ovf_b;
        logic [31:0] sum_a;
        logic [31:0] sum_b;
        n     = sd.size();
        ovf_b = (n > 4);
        acc_b = ovf_b ? 4 : n;
        sum_a = '0;
        sum_b = '0;
        for (int i = 0; i < n; i++) begin
            sum_a += sd[i];
            if (i < acc_b) sum_b += sd[i];
        end
        do_start();
        stream(1'b1);
        check("armA_core_en", core_en_a, 1'b0);
        check("armA_core_rst_n", core_rst_n_a, 1'b0);
        check("armA_ld_ready", ld_ready_a, 1'b0);
        tick();
        check("runA_core_en", core_en_a, 1'b1);
        check("runA_core_rst_n", core_rst_n_a, 1'b1);
        for (int k = 1; k <= h; k++) begin
            core_halt = (k == h);
            tick();
        end
        core_halt = 1'b0;
        check("endA_done", {done_a, busy_a, error_a, core_en_a, core_rst_n_a}, 5'b10001);
        check("endA_run_cycles", run_a, h);
        check("endA_words", words_a, n);
        check("endA_err_code", err_a, 0);
        if (ovf_b) begin
            check("endB_ovf_flags", {done_b, error_b, core_en_b}, 3'b010);
            check("endB_err_code", err_b, 1);
            check("endB_run_cycles", run_b, 0);
        end else if (h <= 8) begin
            check("endB_done", {done_b, error_b, core_en_b}, 3'b100);
            check("endB_run_cycles", run_b, h);
        end else begin
            check("endB_timeout_flags", {done_b, error_b, core_en_b, core_rst_n_b}, 4'b0101);
            check("endB_err_code", err_b, 2);
            check("endB_run_cycles", run_b, 7);
        end
        check("endB_words", words_b, acc_b);
`ifdef LOADER_CHECKSUM_EN
        check("endA_checksum", checksum_a, sum_a);
        check("endB_checksum", checksum_b, sum_b);
`endif
        tick();
        check("holdA_run_cycles", run_a, h);
        check("holdA_core_en", core_en_a, 1'b0);
        check("holdB_core_en", core_en_b, 1'b0);
        check_wr(1'b0, n);
        check_wr(1'b1, acc_b);
    endtask

    task automatic set_stim(input int n, input int gmax);
        sd.delete();
        sg.delete();
        for (int i = 0; i < n; i++) begin
            sd.push_back($urandom);
            sg.push_back((gmax == 0) ? 0 : int'($urandom_range(gmax, 0)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        ld_last = 1'b0; core_halt = 1'b0; ld_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_reset");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_zero("after_reset");

        // Directed load and run with the example program.
        sd = '{32'h3C011001, 32'h34210004, 32'h8C220000};
        sg = '{0, 0, 0};
        session(10);

        // Halt coinciding with the timeout cycle.
        set_stim(1, 0);
        session(8);

        // Valid pattern 1,0,1,0,1.
        set_stim(3, 0);
        sg = '{0, 1, 1};
        session(4);

        // Overflow on B: five beats, none marked last.
        set_stim(5, 0);
        do_start();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = sd[i];
            ld_last  = 1'b0;
            if (i == 4) check("ovfB_ld_ready", ld_ready_b, 1'b0);
            tick();
        end
        ld_valid = 1'b0;
        tick();
        check("ovfB_error", {error_b, err_b}, 3'b101);
        check("ovfB_words", words_b, 4);
        check("ovfA_busy", busy_a, 1'b1);
        check("ovfA_words", words_a, 5);
        check_wr(1'b0, 5);
        check_wr(1'b1, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ovf_abort_A", {busy_a, error_a, ld_ready_a, core_rst_n_a}, 4'b0000);
        check("ovf_abort_B", {busy_b, error_b, ld_ready_b, core_rst_n_b}, 4'b0000);

        // Abort two beats into a load, then restart.
        set_stim(2, 0);
        do_start();
        stream(1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abortA_state", {busy_a, done_a, error_a, ld_ready_a}, 4'b0000);
        check("abortA_core", {core_rst_n_a, core_en_a, imem_we_a}, 3'b000);
        check_wr(1'b0, 2);
        check_wr(1'b1, 2);
        set_stim(1, 0);
        session(5);
        sd = '{32'h00000005, 32'hFFFFFFFE};
        sg = '{0, 0};
        session(2);

        // Randomized sessions against the model.
        for (int s = 0; s < 10; s++) begin
            set_stim(int'($urandom_range(12, 1)), 2);
            session(int'($urandom_range(20, 1)));
        end

        // Asynchronous reset while the core is running.
        set_stim(1, 0);
        do_start();
        stream(1'b1);
        tick();
        check("midrun_core_en", core_en_a, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_zero("midrun_release");
        qa.delete();
        qb.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
